inst_type_stage: RTL and testbench

Registered, multi-lane instruction-type decode stage for the TSC pipeline. Each cycle it classifies up to LANES instruction words into one of eight 3-bit instruction types. It holds the result in a valid/ready output register between fetch and the hazard/issue logic. It also keeps per-type saturating event counters for profiling. It generalises the single-instruction combinational type decoder with lanes, flow control, flush, a strict illegal-opcode mode and statistics.

---
 rtl/inst_type_stage.sv | 196 +++++++++++++++++++
 tb/tb_inst_type_stage.sv | 327 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_type_stage.sv
// Registered multi-lane instruction-type decode stage for the TSC pipeline.
// Each accepted beat classifies every lane into one of eight type codes.
// The beat then sits in a single valid/ready output register.
// Per-type saturating counters profile the beats that leave the stage.
module inst_type_stage #(
  parameter int unsigned LANES      = 2,
  parameter int unsigned WORD_WIDTH = 16,
  parameter int unsigned CNT_WIDTH  = 16,
  parameter bit          STRICT     = 1'b0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [LANES*WORD_WIDTH-1:0] in_inst,
  input  logic [LANES-1:0]            in_lane_en,
  input  logic                        flush,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [LANES*WORD_WIDTH-1:0] out_inst,
  output logic [LANES-1:0]            out_lane_en,
  output logic [LANES*3-1:0]          out_type,
  input  logic [2:0]                  cnt_sel,
  input  logic                        cnt_clear,
  output logic [CNT_WIDTH-1:0]        cnt_value,
  output logic [CNT_WIDTH+1:0]        cnt_total
);

  localparam int unsigned TYPE_W    = 3;
  localparam int unsigned NUM_TYPES = 8;
  localparam int unsigned INC_W     = $clog2(LANES + 1);
  localparam int unsigned TOT_W     = CNT_WIDTH + 2;
  localparam int unsigned CSUM_W    = CNT_WIDTH + INC_W;
  localparam int unsigned TSUM_W    = TOT_W + INC_W;

  // Instruction type codes
  localparam logic [2:0] T_RTYPE   = 3'd0;
  localparam logic [2:0] T_LOAD    = 3'd1;
  localparam logic [2:0] T_STORE   = 3'd2;
  localparam logic [2:0] T_BRANCH  = 3'd3;
  localparam logic [2:0] T_JUMP    = 3'd4;
  localparam logic [2:0] T_OUTPUT  = 3'd5;
  localparam logic [2:0] T_NOP     = 3'd6;
  localparam logic [2:0] T_ILLEGAL = 3'd7;

  // TSC opcodes
  localparam logic [3:0] OP_BNE   = 4'd0;
  localparam logic [3:0] OP_BEQ   = 4'd1;
  localparam logic [3:0] OP_BGZ   = 4'd2;
  localparam logic [3:0] OP_BLZ   = 4'd3;
  localparam logic [3:0] OP_ADI   = 4'd4;
  localparam logic [3:0] OP_ORI   = 4'd5;
  localparam logic [3:0] OP_LHI   = 4'd6;
  localparam logic [3:0] OP_LWD   = 4'd7;
  localparam logic [3:0] OP_SWD   = 4'd8;
  localparam logic [3:0] OP_JMP   = 4'd9;
  localparam logic [3:0] OP_JAL   = 4'd10;
  localparam logic [3:0] OP_RTYPE = 4'd15;

  // R-type function codes with a non-ALU meaning
  localparam logic [5:0] FN_JPR = 6'd25;
  localparam logic [5:0] FN_JRL = 6'd26;
  localparam logic [5:0] FN_WWD = 6'd28;
  localparam logic [5:0] FN_NOP = 6'h3F;

  logic [LANES*TYPE_W-1:0] in_type_c;
  logic                    capture_c;
  logic                    out_fire_c;
  logic [INC_W-1:0]        type_inc_c [NUM_TYPES];
  logic [INC_W-1:0]        lane_inc_c;
  logic [CNT_WIDTH-1:0]    cnt_q      [NUM_TYPES];
  logic [TOT_W-1:0]        total_q;

  // Map one opcode/func pair to its type; disabled lanes always read as NOP.
  function automatic logic [2:0] classify(input logic [3:0] opcode,
                                          input logic [5:0] func,
                                          input logic       en);
    logic [2:0] t;
    t = STRICT ? T_ILLEGAL : T_NOP;
    case (opcode)
      OP_RTYPE: begin
        case (func)
          FN_JPR, FN_JRL: t = T_JUMP;
          FN_WWD:         t = T_OUTPUT;
          FN_NOP:         t = T_NOP;
          default:        t = T_RTYPE;
        endcase
      end
      OP_ADI, OP_ORI:                 t = T_RTYPE;
      OP_LHI, OP_LWD:                 t = T_LOAD;
      OP_SWD:                         t = T_STORE;
      OP_BNE, OP_BEQ, OP_BGZ, OP_BLZ: t = T_BRANCH;
      OP_JMP, OP_JAL:                 t = T_JUMP;
      default:                        ;
    endcase
    if (!en) begin
      t = T_NOP;
    end
    return t;
  endfunction

  // Saturating add for a per-type counter.
  function automatic logic [CNT_WIDTH-1:0] sat_cnt(input logic [CNT_WIDTH-1:0] a,
                                                   input logic [INC_W-1:0]     b);
    logic [CSUM_W-1:0] s;
    s = CSUM_W'(a) + CSUM_W'(b);
    return (|s[CSUM_W-1:CNT_WIDTH]) ? '1 : s[CNT_WIDTH-1:0];
  endfunction

  // Saturating add for the all-lanes total.
  function automatic logic [TOT_W-1:0] sat_tot(input logic [TOT_W-1:0] a,
                                               input logic [INC_W-1:0] b);
    logic [TSUM_W-1:0] s;
    s = TSUM_W'(a) + TSUM_W'(b);
    return (|s[TSUM_W-1:TOT_W]) ? '1 : s[TOT_W-1:0];
  endfunction

  // Handshake qualifiers; flush blocks both capture and release.
  assign in_ready   = !out_valid || out_ready;
  assign capture_c  = in_valid && in_ready && !flush;
  assign out_fire_c = out_valid && out_ready && !flush;

  // Classify every incoming lane.
  always_comb begin
    in_type_c = '0;
    for (int l = 0; l < int'(LANES); l++) begin
      in_type_c[l*TYPE_W +: TYPE_W] =
        classify(in_inst[l*WORD_WIDTH + WORD_WIDTH - 4 +: 4],
                 in_inst[l*WORD_WIDTH +: 6],
                 in_lane_en[l]);
    end
  end

  // Output register: flush wins, then capture, then release.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      out_valid   <= 1'b0;
      out_inst    <= '0;
      out_lane_en <= '0;
      out_type    <= '0;
    end else begin
      if (flush) begin
        out_valid <= 1'b0;
      end else if (capture_c) begin
        out_valid <= 1'b1;
      end else if (out_fire_c) begin
        out_valid <= 1'b0;
      end
      if (capture_c) begin
        out_inst    <= in_inst;
        out_lane_en <= in_lane_en;
        out_type    <= in_type_c;
      end
    end
  end

  // Count enabled lanes of the held beat, per type and overall.
  always_comb begin
    lane_inc_c = '0;
    for (int t = 0; t < int'(NUM_TYPES); t++) begin
      type_inc_c[t] = '0;
    end
    for (int l = 0; l < int'(LANES); l++) begin
      if (out_lane_en[l]) begin
        lane_inc_c = lane_inc_c + INC_W'(1);
        type_inc_c[out_type[l*TYPE_W +: TYPE_W]] =
          type_inc_c[out_type[l*TYPE_W +: TYPE_W]] + INC_W'(1);
      end
    end
  end

  // Profiling counters: clear beats a same-cycle increment.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int t = 0; t < int'(NUM_TYPES); t++) begin
        cnt_q[t] <= '0;
      end
      total_q <= '0;
    end else if (cnt_clear) begin
      for (int t = 0; t < int'(NUM_TYPES); t++) begin
        cnt_q[t] <= '0;
      end
      total_q <= '0;
    end else if (out_fire_c) begin
      for (int t = 0; t < int'(NUM_TYPES); t++) begin
        cnt_q[t] <= sat_cnt(cnt_q[t], type_inc_c[t]);
      end
      total_q <= sat_tot(total_q, lane_inc_c);
    end
  end

  // Counter read-out
  assign cnt_value = cnt_q[cnt_sel];
  assign cnt_total = total_q;

endmodule

// File: tb/tb_inst_type_stage.sv
// Bench for inst_type_stage: two instances (STRICT=0 with 4-bit counters,
// STRICT=1 with 16-bit counters) share one stimulus stream and are compared
// every cycle against a beat-level reference model.
module tb_inst_type_stage;

  localparam int unsigned LANES = 2;
  localparam int unsigned W     = 16;
  localparam int unsigned CW0   = 4;
  localparam int unsigned CW1   = 16;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             in_valid, flush, out_ready, cnt_clear;
  logic [LANES*W-1:0] in_inst;
  logic [LANES-1:0] in_lane_en;
  logic [2:0]       cnt_sel;

  logic               in_ready0, out_valid0, in_ready1, out_valid1;
  logic [LANES*W-1:0] out_inst0, out_inst1;
  logic [LANES-1:0]   out_en0, out_en1;
  logic [LANES*3-1:0] out_type0, out_type1;
  logic [CW0-1:0]     cnt_value0;
  logic [CW0+1:0]     cnt_total0;
  logic [CW1-1:0]     cnt_value1;
  logic [CW1+1:0]     cnt_total1;

  int checks = 0;
  int failures = 0;

  // Reference model state
  bit                 m_valid = 1'b0;
  logic [LANES*W-1:0] m_inst = '0;
  logic [LANES-1:0]   m_en = '0;
  longint             m_cnt [2][8];
  longint             m_tot [2];

  // Hand-computed lane-0 types for words {op,12'h000}, op = 0..15
  int exp_lax    [16] = '{3,3,3,3,0,0,1,1,2,4,4,6,6,6,6,0};
  int exp_strict [16] = '{3,3,3,3,0,0,1,1,2,4,4,7,7,7,7,0};

  always #5 clk = ~clk;

  inst_type_stage #(.LANES(LANES), .WORD_WIDTH(W), .CNT_WIDTH(CW0), .STRICT(1'b0)) dut0 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready0),
    .in_inst(in_inst), .in_lane_en(in_lane_en), .flush(flush),
    .out_valid(out_valid0), .out_ready(out_ready), .out_inst(out_inst0),
    .out_lane_en(out_en0), .out_type(out_type0), .cnt_sel(cnt_sel),
    .cnt_clear(cnt_clear), .cnt_value(cnt_value0), .cnt_total(cnt_total0)
  );

  inst_type_stage #(.LANES(LANES), .WORD_WIDTH(W), .CNT_WIDTH(CW1), .STRICT(1'b1)) dut1 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready1),
    .in_inst(in_inst), .in_lane_en(in_lane_en), .flush(flush),
    .out_valid(out_valid1), .out_ready(out_ready), .out_inst(out_inst1),
    .out_lane_en(out_en1), .out_type(out_type1), .cnt_sel(cnt_sel),
    .cnt_clear(cnt_clear), .cnt_value(cnt_value1), .cnt_total(cnt_total1)
  );

  // Type of one word from the opcode table, by opcode ranges.
  function automatic int model_type(input logic [W-1:0] word, input logic en, input logic strict);
    int op;
    int fn;
    op = int'(word[W-1 -: 4]);
    fn = int'(word[5:0]);
    if (!en) return 6;
    if (op == 15) begin
      if (fn == 25 || fn == 26) return 4;
      if (fn == 28) return 5;
      if (fn == 63) return 6;
      return 0;
    end
    if (op <= 3) return 3;
    if (op <= 5) return 0;
    if (op <= 7) return 1;
    if (op == 8) return 2;
    if (op <= 10) return 4;
    return strict ? 7 : 6;
  endfunction

  function automatic longint cmax(input int d);
    return (d == 0) ? ((longint'(1) << CW0) - 1) : ((longint'(1) << CW1) - 1);
  endfunction

  function automatic longint tmax(input int d);
    return (d == 0) ? ((longint'(1) << (CW0 + 2)) - 1) : ((longint'(1) << (CW1 + 2)) - 1);
  endfunction

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model update on each rising edge (or asynchronous reset).
  initial begin
    bit hs;
    int t;
    forever begin
      @(posedge clk or posedge reset);
      if (reset) begin
        m_valid = 1'b0;
        m_inst  = '0;
        m_en    = '0;
        for (int d = 0; d < 2; d++) begin
          m_tot[d] = 0;
          for (int k = 0; k < 8; k++) m_cnt[d][k] = 0;
        end
      end else begin
        hs = m_valid && out_ready && !flush;
        if (cnt_clear) begin
          for (int d = 0; d < 2; d++) begin
            m_tot[d] = 0;
            for (int k = 0; k < 8; k++) m_cnt[d][k] = 0;
          end
        end else if (hs) begin
          for (int l = 0; l < int'(LANES); l++) begin
            if (m_en[l]) begin
              for (int d = 0; d < 2; d++) begin
                t = model_type(m_inst[l*W +: W], 1'b1, d == 1);
                if (m_cnt[d][t] < cmax(d)) m_cnt[d][t] = m_cnt[d][t] + 1;
                if (m_tot[d] < tmax(d)) m_tot[d] = m_tot[d] + 1;
              end
            end
          end
        end
        if (flush) begin
          m_valid = 1'b0;
        end else if (in_valid && (!m_valid || out_ready)) begin
          m_valid = 1'b1;
          m_inst  = in_inst;
          m_en    = in_lane_en;
        end else if (hs) begin
          m_valid = 1'b0;
        end
      end
    end
  end

  task automatic cmp_dut(input int d, input logic ir, input logic ov,
                         input logic [LANES*W-1:0] oi, input logic [LANES-1:0] oe,
                         input logic [LANES*3-1:0] ot, input logic [63:0] cv,
                         input logic [63:0] ct);
    chk($sformatf("d%0d in_ready", d), 64'(ir), 64'(!m_valid || out_ready));
    chk($sformatf("d%0d out_valid", d), 64'(ov), 64'(m_valid));
    if (m_valid) begin
      chk($sformatf("d%0d out_inst", d), 64'(oi), 64'(m_inst));
      chk($sformatf("d%0d out_lane_en", d), 64'(oe), 64'(m_en));
      for (int l = 0; l < int'(LANES); l++) begin
        chk($sformatf("d%0d out_type[%0d]", d, l), 64'(ot[l*3 +: 3]),
            64'(model_type(m_inst[l*W +: W], m_en[l], d == 1)));
      end
    end
    chk($sformatf("d%0d cnt_value[%0d]", d, cnt_sel), cv, 64'(m_cnt[d][cnt_sel]));
    chk($sformatf("d%0d cnt_total", d), ct, 64'(m_tot[d]));
  endtask

  // Every-cycle comparison against the model, away from the active edge.
  initial begin
    forever begin
      @(negedge clk);
      cmp_dut(0, in_ready0, out_valid0, out_inst0, out_en0, out_type0,
              64'(cnt_value0), 64'(cnt_total0));
      cmp_dut(1, in_ready1, out_valid1, out_inst1, out_en1, out_type1,
              64'(cnt_value1), 64'(cnt_total1));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // One beat with the given lane-0 word; lane 1 carries a func-63 NOP.
  task automatic type_beat(input logic [15:0] w, input int e0, input int e1);
    step();
    in_valid = 1'b1; in_inst = {16'hF03F, w}; in_lane_en = 2'b11; out_ready = 1'b1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk($sformatf("lit type %h lax", w), 64'(out_type0[2:0]), 64'(e0));
    chk($sformatf("lit type %h strict", w), 64'(out_type1[2:0]), 64'(e1));
    chk("lit lane1 func63", 64'(out_type0[5:3]), 64'(6));
  endtask

  function automatic logic [15:0] rand_word();
    logic [15:0] w;
    w = 16'($urandom);
    case ($urandom_range(0, 7))
      0: w[5:0] = 6'd25;
      1: w[5:0] = 6'd26;
      2: w[5:0] = 6'd28;
      3: w[5:0] = 6'h3F;
      default: ;
    endcase
    return w;
  endfunction

  initial begin
    in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0; cnt_clear = 1'b0;
    in_inst = '0; in_lane_en = '0; cnt_sel = 3'd0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // Reset values
    @(negedge clk);
    chk("rst out_valid", 64'(out_valid0), 64'(0));
    chk("rst in_ready", 64'(in_ready0), 64'(1));
    chk("rst out_inst", 64'(out_inst0), 64'(0));
    chk("rst out_type", 64'(out_type1), 64'(0));
    chk("rst out_lane_en", 64'(out_en1), 64'(0));
    chk("rst cnt_total", 64'(cnt_total0), 64'(0));

    // First beat: LWD + WWD
    step();
    in_valid = 1'b1; in_inst = {16'hF01C, 16'h7000}; in_lane_en = 2'b11;
    out_ready = 1'b1; cnt_sel = 3'd1;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lit first out_valid", 64'(out_valid0), 64'(1));
    chk("lit first out_type", 64'(out_type0), 64'(6'b101_001));
    step();
    @(negedge clk);
    chk("lit first cnt LOAD", 64'(cnt_value0), 64'(1));
    chk("lit first cnt_total", 64'(cnt_total1), 64'(2));
    step();
    cnt_sel = 3'd5;
    @(negedge clk);
    chk("lit first cnt OUTPUT", 64'(cnt_value1), 64'(1));

    // Classification sweep
    for (int op = 0; op < 16; op++) begin
      type_beat(16'(op << 12), exp_lax[op], exp_strict[op]);
    end
    type_beat(16'hF019, 4, 4);
    type_beat(16'hF01A, 4, 4);
    type_beat(16'hF01C, 5, 5);
    type_beat(16'hF03F, 6, 6);

    // Backpressure
    step();
    in_valid = 1'b1; in_inst = {16'h8000, 16'h4000}; in_lane_en = 2'b11; out_ready = 1'b0;
    step();
    in_inst = {16'h9000, 16'h6000};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("lit bp in_ready", 64'(in_ready0), 64'(0));
      chk("lit bp out_inst", 64'(out_inst0), 64'(32'h8000_4000));
      step();
    end
    out_ready = 1'b1;
    repeat (3) step();
    in_valid = 1'b0;
    repeat (2) step();

    // Flush while holding a beat with a new beat offered
    in_valid = 1'b1; in_inst = {16'h1000, 16'h2000}; out_ready = 1'b0;
    step();
    in_inst = {16'hA000, 16'hA000}; flush = 1'b1;
    step();
    flush = 1'b0; in_valid = 1'b0;
    @(negedge clk);
    chk("lit flush out_valid", 64'(out_valid0), 64'(0));
    out_ready = 1'b1;

    // Saturation of the 4-bit BRANCH counter
    step();
    cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0; cnt_sel = 3'd3;
    in_valid = 1'b1; in_inst = {16'h1000, 16'h0000}; in_lane_en = 2'b11;
    repeat (20) step();
    in_valid = 1'b0;
    step();
    @(negedge clk);
    chk("lit sat BRANCH w4", 64'(cnt_value0), 64'(15));
    chk("lit sat BRANCH w16", 64'(cnt_value1), 64'(40));
    chk("lit sat total w4", 64'(cnt_total0), 64'(40));

    // Clear coincident with a handshake
    step();
    in_valid = 1'b1;
    step();
    in_valid = 1'b0; cnt_clear = 1'b1;
    step();
    cnt_clear = 1'b0;
    @(negedge clk);
    chk("lit clear BRANCH", 64'(cnt_value0), 64'(0));
    chk("lit clear total", 64'(cnt_total1), 64'(0));

    // Lane mask: lane 1 SWD disabled
    step();
    in_valid = 1'b1; in_inst = {16'h8000, 16'h7000}; in_lane_en = 2'b01; cnt_sel = 3'd2;
    step();
    in_valid = 1'b0;
    @(negedge clk);
    chk("lit mask lane1 type", 64'(out_type0[5:3]), 64'(6));
    chk("lit mask lane0 type", 64'(out_type1[2:0]), 64'(1));
    step();
    @(negedge clk);
    chk("lit mask STORE cnt", 64'(cnt_value0), 64'(0));
    chk("lit mask total", 64'(cnt_total0), 64'(1));

    // Randomized traffic, with one reset in the middle
    for (int c = 0; c < 3000; c++) begin
      step();
      in_valid   = ($urandom_range(0, 3) != 0);
      out_ready  = ($urandom_range(0, 9) < 7);
      flush      = ($urandom_range(0, 19) == 0);
      cnt_clear  = ($urandom_range(0, 79) == 0);
      in_inst    = {rand_word(), rand_word()};
      in_lane_en = 2'($urandom);
      cnt_sel    = 3'($urandom);
      if (c == 1500) reset = 1'b1;
      if (c == 1503) reset = 1'b0;
    end
    step();
    in_valid = 1'b0; flush = 1'b0; cnt_clear = 1'b0;
    repeat (2) @(negedge clk);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
